// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared msrv32 memory-arbiter types and constants
package msrv32_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [3:0] FETCH_MASK          = 4'hF;
  localparam int         TIMEOUT_CYC_DEFAULT = 16;
  localparam int         WAIT_CNT_W          = 8;

endpackage

// File: rtl/msrv32_arb_rr2.sv
// rtl/msrv32_arb_rr2.sv - two-port fixed-priority arbiter with anti-starvation override
module msrv32_arb_rr2 #(
  parameter int D_PRIORITY = 1
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant_d,
  input  logic last_valid,
  output logic gnt_i,
  output logic gnt_d
);

  localparam logic FAV_D = (D_PRIORITY != 0);

  logic override;
  logic pick_d;

  // The favoured port yields only when it also took the previous grant.
  always_comb begin
    override = last_valid & (last_grant_d == FAV_D);
    pick_d   = FAV_D ^ override;
    gnt_d    = d_req & (~i_req | pick_d);
    gnt_i    = i_req & (~d_req | ~pick_d);
  end

endmodule

// File: rtl/msrv32_mem_arbiter.sv
// rtl/msrv32_mem_arbiter.sv - shares one memory bus between fetch and data ports
module msrv32_mem_arbiter
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int D_PRIORITY  = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic [31:0] i_rdata_out,
  output logic        i_done_out,
  output logic        i_err_out,
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic        d_done_out,
  output logic        d_err_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_mask_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  output logic        busy_out
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  last_grant_d;
  logic                  last_valid;
  logic                  i_req_eff;
  logic                  d_req_eff;
  logic                  gnt_i;
  logic                  gnt_d;
  logic                  start_i;
  logic                  start_d;
  logic                  finish_ok;
  logic                  finish_err;
  logic                  in_busy;

  // A port whose completion pulse is showing is still holding its old request.
  assign i_req_eff = i_req_in & ~i_done_out & ~i_err_out;
  assign d_req_eff = d_req_in & ~d_done_out & ~d_err_out;

  msrv32_arb_rr2 #(
    .D_PRIORITY (D_PRIORITY)
  ) u_arb (
    .i_req        (i_req_eff),
    .d_req        (d_req_eff),
    .last_grant_d (last_grant_d),
    .last_valid   (last_valid),
    .gnt_i        (gnt_i),
    .gnt_d        (gnt_d)
  );

  assign in_busy     = (state != ARB_IDLE);
  assign busy_out    = in_busy;
  assign bus_req_out = in_busy;

  always_comb begin
    state_nxt  = state;
    start_i    = 1'b0;
    start_d    = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (gnt_d) begin
          start_d   = 1'b1;
          state_nxt = ARB_BUSY_D;
        end else if (gnt_i) begin
          start_i   = 1'b1;
          state_nxt = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack_in) begin
          finish_ok = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          finish_err = 1'b1;
          state_nxt  = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      wait_cnt      <= '0;
      last_grant_d  <= 1'b1;
      last_valid    <= 1'b0;
      bus_we_out    <= 1'b0;
      bus_addr_out  <= '0;
      bus_wdata_out <= '0;
      bus_mask_out  <= '0;
      i_rdata_out   <= '0;
      d_rdata_out   <= '0;
      i_done_out    <= 1'b0;
      i_err_out     <= 1'b0;
      d_done_out    <= 1'b0;
      d_err_out     <= 1'b0;
    end else begin
      i_done_out <= 1'b0;
      i_err_out  <= 1'b0;
      d_done_out <= 1'b0;
      d_err_out  <= 1'b0;

      if (start_d) begin
        bus_we_out    <= d_we_in;
        bus_addr_out  <= d_addr_in;
        bus_wdata_out <= d_wdata_in;
        bus_mask_out  <= d_mask_in;
        wait_cnt      <= '0;
        last_grant_d  <= 1'b1;
        last_valid    <= 1'b1;
      end else if (start_i) begin
        bus_we_out    <= 1'b0;
        bus_addr_out  <= i_addr_in;
        bus_wdata_out <= '0;
        bus_mask_out  <= FETCH_MASK;
        wait_cnt      <= '0;
        last_grant_d  <= 1'b0;
        last_valid    <= 1'b1;
      end else if (in_busy && !finish_ok && !finish_err) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (finish_ok) begin
        if (state == ARB_BUSY_I) begin
          i_rdata_out <= bus_rdata_in;
          i_done_out  <= 1'b1;
        end else begin
          if (!bus_we_out) begin
            d_rdata_out <= bus_rdata_in;
          end
          d_done_out <= 1'b1;
        end
      end

      if (finish_err) begin
        if (state == ARB_BUSY_I) begin
          i_err_out <= 1'b1;
        end else begin
          d_err_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/msrv32_mem_arbiter.md
MSRV32_MEM_ARBITER -- requirements
Module: msrv32_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, is the number of BUSY cycles without bus_ack_in after which a transaction is aborted; legal range is 2..255.
REQ-002 Parameter D_PRIORITY, default 1: when 1, the data port wins when both ports request from IDLE with no fairness override.
REQ-003 ms_riscv32_mp_clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 ms_riscv32_mp_rst_in, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 i_req_in, input, 1 bit: instruction-fetch request, held high until i_done_out or i_err_out.
REQ-006 i_addr_in, input, 32 bits: fetch address.
REQ-007 i_rdata_out, output, 32 bits: fetched word.
REQ-008 i_done_out, output, 1 bit: one-cycle success pulse for the fetch port.
REQ-009 i_err_out, output, 1 bit: one-cycle timeout pulse for the fetch port.
REQ-010 d_req_in (1), d_we_in (1), d_addr_in (32), d_wdata_in (32), d_mask_in (4), all inputs: data request, write enable, address, write data, byte mask; request held until done or error.
REQ-011 d_rdata_out (32), d_done_out (1), d_err_out (1), all outputs: data-port equivalents of REQ-007 to REQ-009.
REQ-012 bus_req_out (1), bus_we_out (1), bus_addr_out (32), bus_wdata_out (32), bus_mask_out (4), all outputs: shared memory bus request.
REQ-013 bus_ack_in (1), bus_rdata_in (32), inputs: transaction completion; read data is valid in the ack cycle.
REQ-014 busy_out, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM has three states:
- IDLE
- BUSY_I
- BUSY_D
REQ-016 From IDLE, with a request pending, the FSM latches the owner's address, we, wdata and mask into bus registers and moves to BUSY_I or BUSY_D.
REQ-017 Arbitration when both ports request in IDLE:
- The data port wins per D_PRIORITY, unless the previous grant went to the same port that D_PRIORITY favours and the other port is also requesting; the other port then wins (no back-to-back starvation).
REQ-018 In BUSY_x, bus_req_out is 1 and every bus_* output is driven only from the latched registers; requester input changes have no effect.
REQ-019 Fetch transactions always drive bus_we_out=0 and bus_mask_out=4'hF.
REQ-020 In BUSY_x with bus_ack_in=1, the FSM registers bus_rdata_in into x_rdata_out, pulses x_done_out for exactly 1 cycle on the next edge, and returns to IDLE.
- Latency from request to done with a zero-wait bus is 2 cycles.
REQ-021 x_rdata_out holds its value until the next completed read on the same port; write completions leave d_rdata_out unchanged.
REQ-022 The wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
- When it reaches TIMEOUT_CYC-1 without ack, the FSM pulses x_err_out, drops bus_req_out, and returns to IDLE.
- An ack in that same cycle takes precedence: done is pulsed, err is not.
REQ-023 Re-arbitration: IDLE is always visited for at least 1 cycle between transactions; bus_req_out is low in IDLE.
REQ-024 A requester that deasserts its request mid-transaction does not abort it; its done or error pulse is still issued.
REQ-025 Done and error are never asserted together, and never on both ports in the same cycle.

Reset
REQ-026 On reset:
- FSM enters IDLE; last-grant indicator is set to data.
- Wait counter and all bus_*, *_rdata_out, *_done_out, *_err_out and busy_out outputs are 0.
REQ-027 Reset asserted mid-transaction aborts it with no done or error pulse; bus_req_out falls asynchronously.

Structure
REQ-028 FSM state encoding, the fetch mask constant 4'hF and the TIMEOUT_CYC default belong in the shared msrv32 package.
REQ-029 The arbitration decision is one combinational sub-module, msrv32_arb_rr2 (2 requests, last-grant input, grant outputs); all else is in the top module.

Verification
REQ-030 Scenario: i_req only, addr 0x100, ack on the 1st BUSY cycle with rdata 0x00000013 -> bus_addr_out=0x100, bus_we_out=0, i_done_out pulses 2 cycles after request, i_rdata_out=0x13.
REQ-031 Scenario: i_req and d_req (write 0x2000, data 0xDEADBEEF, mask 4'b0011) together, D_PRIORITY=1, after reset -> data is served first, fetch second, bus_mask_out=0011 during the data transaction.
REQ-032 Scenario: both ports continuously requesting for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-033 Scenario: d_req read with no ack, TIMEOUT_CYC=16 -> d_err_out pulses after 16 BUSY cycles, bus_req_out drops, d_done_out stays 0.
REQ-034 Scenario: ack arrives in the same cycle as the timeout -> done pulses, err stays 0.
REQ-035 Scenario: reset low during BUSY_D -> bus_req_out goes 0 immediately, no pulse on either port, and the FSM is in IDLE after reset is released.
